fxp_addsub_pipe: RTL and testbench

- Parametrised successor to the team's combinational fixed-point adder.
- Signed two's-complement add/subtract of two operands, each with its own integer/fraction split, into a third output format.
- Adds selectable round-half-up or truncate, and selectable saturate or wrap.
- Two-stage registered pipeline with valid/ready handshake and per-result plus sticky overflow; sits in datapaths as a streaming arithmetic element.

---
 rtl/fxp_pkg.sv | 20 ++
 rtl/fxp_round_sat.sv | 69 ++++++
 rtl/fxp_addsub_pipe.sv | 133 +++++++++++++
 tb/tb_fxp_addsub_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers: width arithmetic, saturation limits
// and mode encodings for the add/sub pipeline and later multiply/MAC blocks.
package fxp_pkg;

    typedef enum logic { TRUNC = 1'b0, RHU = 1'b1 } rnd_mode_e;
    typedef enum logic { WRAP = 1'b0, SAT = 1'b1 } ovf_mode_e;

    function automatic int fxp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [63:0] fxp_sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] fxp_sat_min(input int w);
        return ~fxp_sat_max(w);
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational requantiser: aligns a signed fixed-point value to the
// output fraction (round-half-up or floor), then saturates or wraps.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int IN_W = 9,
    parameter int IN_F = 4,
    parameter int WIO  = 4,
    parameter int WFO  = 4
) (
    input  logic [IN_W-1:0]    value,
    input  logic               rnd_en,
    input  logic               sat_en,
    output logic [WIO+WFO-1:0] result,
    output logic               ovf
);

    localparam int OW = WIO + WFO;
    localparam int D  = IN_F - WFO;
    localparam int AW = (D > 0) ? IN_W + 1 - D : IN_W - D;

    logic signed [AW-1:0] aligned;

    generate
        if (D > 0) begin : g_round
            localparam logic [IN_W:0] HALF = (IN_W + 1)'(1) << (D - 1);
            logic [IN_W:0] ext;
            logic          unused_lsb;
            // One guard bit keeps the rounding increment exact.
            assign ext = {value[IN_W-1], value}
                       + ((rnd_en == RHU) ? HALF : '0);
            assign aligned    = ext[IN_W:D];
            assign unused_lsb = ^ext[D-1:0];
        end else begin : g_pad
            logic unused_rnd;
            assign unused_rnd = rnd_en;
            if (D == 0) begin : g_eq
                assign aligned = value;
            end else begin : g_zp
                localparam int P = -D;
                assign aligned = {value, {P{1'b0}}};
            end
        end
    endgenerate

    generate
        if (AW <= OW) begin : g_widen
            logic unused_sat;
            assign unused_sat = sat_en;
            assign result = OW'(aligned);
            assign ovf    = 1'b0;
        end else begin : g_narrow
            localparam logic [OW-1:0] MAXV = OW'(fxp_sat_max(OW));
            localparam logic [OW-1:0] MINV = OW'(fxp_sat_min(OW));
            logic [AW-OW:0] hi_bits;
            logic           fits;
            assign hi_bits = aligned[AW-1:OW-1];
            assign fits    = (&hi_bits) | ~(|hi_bits);
            assign ovf     = ~fits;
            always_comb begin
                result = aligned[OW-1:0];
                if (!fits && sat_en == SAT) begin
                    result = aligned[AW-1] ? MINV : MAXV;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fxp_addsub_pipe.sv
// Two-stage streaming fixed-point add/sub with rounding, saturation,
// valid/ready handshake and sticky overflow.
module fxp_addsub_pipe
    import fxp_pkg::*;
#(
    parameter int WI1 = 4,
    parameter int WF1 = 4,
    parameter int WI2 = 4,
    parameter int WF2 = 4,
    parameter int WIO = 4,
    parameter int WFO = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WI1+WF1-1:0]   in1,
    input  logic [WI2+WF2-1:0]   in2,
    input  logic                 sub,
    input  logic                 rnd_en,
    input  logic                 sat_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIO+WFO-1:0]   out,
    output logic                 ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ovf_sticky,
    input  logic                 clear
);

    localparam int WI = fxp_max(WI1, WI2);
    localparam int WF = fxp_max(WF1, WF2);
    localparam int SW = WI + WF + 1;
    localparam int OW = WIO + WFO;

    logic [SW-1:0] a_ext;
    logic [SW-1:0] b_ext;
    logic [SW-1:0] addsub;

    logic [SW-1:0] s1_sum_q, s1_sum_d;
    logic          s1_rnd_q, s1_rnd_d;
    logic          s1_sat_q, s1_sat_d;
    logic          s1_valid_q, s1_valid_d;
    logic [OW-1:0] out_q, out_d;
    logic          ovf_q, ovf_d;
    logic          out_valid_q, out_valid_d;
    logic          sticky_q, sticky_d;

    logic [OW-1:0] rs_result;
    logic          rs_ovf;
    logic          s1_adv;
    logic          s2_adv;

    // One spare integer bit makes the add/sub exact.
    assign a_ext  = SW'($signed(in1)) << (WF - WF1);
    assign b_ext  = SW'($signed(in2)) << (WF - WF2);
    assign addsub = sub ? (a_ext + ~b_ext + SW'(1)) : (a_ext + b_ext);

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    fxp_round_sat #(
        .IN_W (SW),
        .IN_F (WF),
        .WIO  (WIO),
        .WFO  (WFO)
    ) u_round_sat (
        .value  (s1_sum_q),
        .rnd_en (s1_rnd_q),
        .sat_en (s1_sat_q),
        .result (rs_result),
        .ovf    (rs_ovf)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        s1_rnd_d    = s1_rnd_q;
        s1_sat_d    = s1_sat_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        ovf_d       = ovf_q;
        sticky_d    = sticky_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sum_d = addsub;
                s1_rnd_d = rnd_en;
                s1_sat_d = sat_en;
            end
        end
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d = rs_result;
                ovf_d = rs_ovf;
            end
        end
        if (clear) begin
            sticky_d = 1'b0;
        end else if (out_valid_q && out_ready && ovf_q) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_rnd_q    <= 1'b0;
            s1_sat_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_rnd_q    <= s1_rnd_d;
            s1_sat_q    <= s1_sat_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out        = out_q;
    assign ovf        = ovf_q;
    assign out_valid  = out_valid_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fxp_addsub_pipe.sv
// Bench for fxp_addsub_pipe: default Q4.4 output and a Q4.2 output
// instance share stimulus; results are checked against an integer model.
module tb_fxp_addsub_pipe;
    import fxp_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in1 = '0;
    logic [7:0] in2 = '0;
    logic       sub = 1'b0;
    logic       rnd_en = 1'b0;
    logic       sat_en = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       clear = 1'b0;

    logic       in_ready_a, in_ready_b;
    logic       out_valid_a, out_valid_b;
    logic       ovf_a, ovf_b;
    logic       sticky_a, sticky_b;
    logic [7:0] out_a;
    logic [5:0] out_b;

    int n_chk = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [7:0] ea;
        logic       oa;
        logic [5:0] eb;
        logic       ob;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic       r;
        logic       t;
        logic [7:0] ea;
        logic       oa;
        logic [5:0] eb;
        logic       ob;
    } vec_t;

    exp_t q[$];
    vec_t vt[9];

    fxp_addsub_pipe dut_a (
        .clk(clk), .reset(reset), .in1(in1), .in2(in2), .sub(sub),
        .rnd_en(rnd_en), .sat_en(sat_en), .in_valid(in_valid),
        .in_ready(in_ready_a), .out(out_a), .ovf(ovf_a),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .ovf_sticky(sticky_a), .clear(clear)
    );

    fxp_addsub_pipe #(.WIO(4), .WFO(2)) dut_b (
        .clk(clk), .reset(reset), .in1(in1), .in2(in2), .sub(sub),
        .rnd_en(rnd_en), .sat_en(sat_en), .in_valid(in_valid),
        .in_ready(in_ready_b), .out(out_b), .ovf(ovf_b),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .ovf_sticky(sticky_b), .clear(clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Real-number semantics in units of 2^-4, requantised to Q(wio).(wfo).
    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic r, input logic t,
                         input int wio, input int wfo,
                         output int res, output bit o);
        int av, bv, sum, v, sh, w, hi, lo;
        av  = int'($signed(a));
        bv  = int'($signed(b));
        sum = s ? av - bv : av + bv;
        if (wfo < 4) begin
            sh = 4 - wfo;
            v  = r ? ((sum + (1 << (sh - 1))) >>> sh) : (sum >>> sh);
        end else begin
            v = sum <<< (wfo - 4);
        end
        w  = wio + wfo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        o  = (v > hi) || (v < lo);
        if (o && t) v = (v > hi) ? hi : lo;
        res = v & ((1 << w) - 1);
    endtask

    task automatic exp_of(input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic r, input logic t,
                          output exp_t e);
        int ra, rb;
        bit oa, ob;
        model(a, b, s, r, t, 4, 4, ra, oa);
        model(a, b, s, r, t, 4, 2, rb, ob);
        e.ea = 8'(ra);
        e.oa = oa;
        e.eb = 6'(rb);
        e.ob = ob;
    endtask

    bit         prev_stall = 1'b0;
    logic [7:0] prev_out = '0;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("mon_rdy_sync", int'(in_ready_b), int'(in_ready_a));
            check("mon_vld_sync", int'(out_valid_b), int'(out_valid_a));
            if (prev_stall) check("mon_hold", int'(out_a), int'(prev_out));
            if (in_valid && in_ready_a) begin
                exp_of(in1, in2, sub, rnd_en, sat_en, e);
                q.push_back(e);
            end
            if (out_valid_a && out_ready) begin
                if (q.size() == 0) begin
                    check("mon_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("mon_out_a", int'(out_a), int'(e.ea));
                    check("mon_ovf_a", int'(ovf_a), int'(e.oa));
                    check("mon_out_b", int'(out_b), int'(e.eb));
                    check("mon_ovf_b", int'(ovf_b), int'(e.ob));
                end
            end
            prev_stall = out_valid_a && !out_ready;
            prev_out   = out_a;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [7:0] ta[3];
    logic [7:0] tb[3];
    logic       ts[3];
    exp_t       te[3];
    logic [7:0] got[$];
    int idx, first, last;
    bit seen;

    initial begin
        vt[0] = '{8'h7F, 8'h01, 1'b0, TRUNC, SAT,  8'h7F, 1'b1, 6'h1F, 1'b1};
        vt[1] = '{8'h7F, 8'h01, 1'b0, TRUNC, WRAP, 8'h80, 1'b1, 6'h20, 1'b1};
        vt[2] = '{8'h80, 8'h01, 1'b1, TRUNC, SAT,  8'h80, 1'b1, 6'h20, 1'b1};
        vt[3] = '{8'h30, 8'h18, 1'b1, TRUNC, SAT,  8'h18, 1'b0, 6'h06, 1'b0};
        vt[4] = '{8'h06, 8'h00, 1'b0, RHU,   SAT,  8'h06, 1'b0, 6'h02, 1'b0};
        vt[5] = '{8'h06, 8'h00, 1'b0, TRUNC, SAT,  8'h06, 1'b0, 6'h01, 1'b0};
        vt[6] = '{8'hFA, 8'h00, 1'b0, RHU,   SAT,  8'hFA, 1'b0, 6'h3F, 1'b0};
        vt[7] = '{8'hFA, 8'h00, 1'b0, TRUNC, SAT,  8'hFA, 1'b0, 6'h3E, 1'b0};
        vt[8] = '{8'h7F, 8'h00, 1'b0, RHU,   SAT,  8'h7F, 1'b0, 6'h1F, 1'b1};

        #1;
        check("rst_valid", int'(out_valid_a), 0);
        check("rst_out", int'(out_a), 0);
        check("rst_ovf", int'(ovf_a), 0);
        check("rst_sticky", int'(sticky_a), 0);
        check("rst_in_ready", int'(in_ready_a), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Directed table, one transaction at a time.
        for (int i = 0; i < 9; i++) begin
            in1 = vt[i].a; in2 = vt[i].b; sub = vt[i].s;
            rnd_en = vt[i].r; sat_en = vt[i].t;
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_early", i), int'(out_valid_a), 0);
            @(negedge clk);
            check($sformatf("v%0d_valid", i), int'(out_valid_a), 1);
            check($sformatf("v%0d_out_a", i), int'(out_a), int'(vt[i].ea));
            check($sformatf("v%0d_ovf_a", i), int'(ovf_a), int'(vt[i].oa));
            check($sformatf("v%0d_out_b", i), int'(out_b), int'(vt[i].eb));
            check($sformatf("v%0d_ovf_b", i), int'(ovf_b), int'(vt[i].ob));
        end
        @(posedge clk); #1;
        check("sticky_a_set", int'(sticky_a), 1);
        check("sticky_b_set", int'(sticky_b), 1);

        // Clear wins over a same-cycle overflow handshake.
        in1 = 8'h7F; in2 = 8'h01; sub = 1'b0; rnd_en = 1'b0; sat_en = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        check("clr_pre_ovf", int'(ovf_a), 1);
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        check("clr_sticky", int'(sticky_a), 0);
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        check("reset_sticky", int'(sticky_a), 1);

        // Backpressure: three offers against a stalled output.
        ta = '{8'h10, 8'h7F, 8'h05};
        tb = '{8'h20, 8'h7F, 8'h09};
        ts = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) exp_of(ta[k], tb[k], ts[k], 1'b0, 1'b1, te[k]);
        rnd_en = 1'b0; sat_en = 1'b1; out_ready = 1'b0; idx = 0;
        for (int c = 0; c < 6; c++) begin
            if (idx < 3) begin
                in1 = ta[idx]; in2 = tb[idx]; sub = ts[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready_a) idx++;
            @(posedge clk); #1;
        end
        check("bp_accepts", idx, 2);
        check("bp_in_ready", int'(in_ready_a), 0);
        check("bp_hold_valid", int'(out_valid_a), 1);
        check("bp_hold_out", int'(out_a), int'(te[0].ea));
        out_ready = 1'b1; first = -1; last = -1;
        for (int c = 0; c < 12; c++) begin
            if (idx < 3) begin
                in1 = ta[idx]; in2 = tb[idx]; sub = ts[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready_a) idx++;
            if (out_valid_a && out_ready) begin
                got.push_back(out_a);
                if (first < 0) first = c;
                last = c;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_count", got.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) check($sformatf("bp_order%0d", k), int'(got[k]), int'(te[k].ea));
        end
        check("bp_rate", last - first, 2);

        // Asynchronous reset with two transactions in flight.
        out_ready = 1'b0; sat_en = 1'b0;
        in1 = 8'h7F; in2 = 8'h7F; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 in_valid = 1'b0;
        check("ar_pre_valid", int'(out_valid_a), 1);
        #2 reset = 1'b0;
        #1;
        check("ar_valid", int'(out_valid_a), 0);
        check("ar_out", int'(out_a), 0);
        check("ar_ovf", int'(ovf_a), 0);
        check("ar_sticky", int'(sticky_a), 0);
        check("ar_out_b", int'(out_b), 0);
        out_ready = 1'b1;
        @(negedge clk) reset = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid_a) seen = 1'b1;
        end
        check("ar_no_ghost", int'(seen), 0);
        in1 = 8'h30; in2 = 8'h18; sub = 1'b1; sat_en = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        check("ar_new_valid", int'(out_valid_a), 1);
        check("ar_new_out", int'(out_a), 8'h18);
        repeat (2) @(posedge clk);
        #1;

        // Random traffic against the model via the monitor.
        mon_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            in1       = 8'($urandom);
            in2       = 8'($urandom);
            sub       = 1'($urandom);
            rnd_en    = 1'($urandom);
            sat_en    = 1'($urandom);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (q.size() != 0) begin
                @(posedge clk); #1;
            end
        end
        mon_en = 1'b0;
        check("drain_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
